// File: rtl/udma_filter_pkg.sv
// Shared types for the uDMA filter TX address generators: mode, datasize and
// FSM state encodings plus the per-element byte increment.
package udma_filter_pkg;

    typedef enum logic [1:0] {
        LINEAR   = 2'b00,
        STRIDE2D = 2'b01,
        CIRCULAR = 2'b10,
        RSVD     = 2'b11
    } filt_mode_e;

    typedef enum logic [1:0] {
        BYTE  = 2'b00,
        HALF  = 2'b01,
        WORD  = 2'b10,
        WORD2 = 2'b11
    } filt_dsize_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } addrgen_state_e;

    function automatic logic [2:0] dsize_inc(input filt_dsize_e dsize);
        logic [2:0] inc;
        case (dsize)
            BYTE:    inc = 3'd1;
            HALF:    inc = 3'd2;
            default: inc = 3'd4;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/udma_filt_dim_cnt.sv
// One dimension of the filter address walk: counts 0..len-1 and flags the
// terminal count so the next dimension can advance.
module udma_filt_dim_cnt #(
    parameter int TRANS_SIZE = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [TRANS_SIZE-1:0] len,
    output logic                  tc,
    output logic                  wrap
);

    logic [TRANS_SIZE-1:0] count;

    assign tc   = (count == len - TRANS_SIZE'(1));
    assign wrap = enable & tc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + TRANS_SIZE'(1);
        end
    end

endmodule

// File: rtl/udma_filter_tx_addrgen.sv
// L2 read-address generator for one filter TX channel (linear, 2D strided,
// circular). Define UDMA_FILT_ADDRGEN_STALL_CNT_EN to add stall_cnt_o.
module udma_filter_tx_addrgen
    import udma_filter_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 15,
    parameter int TRANS_SIZE     = 15
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cfg_start_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
    input  logic [TRANS_SIZE-1:0]     cfg_len2_i,
    output logic                      req_o,
    input  logic                      gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0] addr_o,
    output logic [1:0]                datasize_o,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);

    addrgen_state_e state, state_next;

    logic [L2_AWIDTH_NOAL-1:0] addr_q, row_base_q, next_row_base;
    logic [1:0]                dsize_q;
    filt_mode_e                mode_q;
    logic [TRANS_SIZE-1:0]     len0_q, len1_q, len2_q;

    logic start_ok, empty, two_dim, cfg_two_dim;
    logic hs, last_elem;
    logic i_tc, i_wrap, j_tc, j_wrap;

    assign two_dim     = (mode_q == STRIDE2D) || (mode_q == CIRCULAR);
    assign cfg_two_dim = (filt_mode_e'(cfg_mode_i) == STRIDE2D) ||
                         (filt_mode_e'(cfg_mode_i) == CIRCULAR);
    assign empty       = (cfg_len0_i == '0) || (cfg_two_dim && (cfg_len1_i == '0));
    assign last_elem   = i_tc && (!two_dim || j_tc);
    assign hs          = req_o & gnt_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        req_o      = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        last_o     = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start_i) begin
                    start_ok   = 1'b1;
                    state_next = empty ? DONE : RUN;
                end
            end
            RUN: begin
                req_o  = 1'b1;
                busy_o = 1'b1;
                last_o = last_elem;
                if (gnt_i && last_elem) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    udma_filt_dim_cnt #(.TRANS_SIZE(TRANS_SIZE)) i_cnt (
        .clk    (clk_i),
        .rstn   (rstn_i),
        .clear  (start_ok),
        .enable (hs),
        .len    (len0_q),
        .tc     (i_tc),
        .wrap   (i_wrap)
    );

    udma_filt_dim_cnt #(.TRANS_SIZE(TRANS_SIZE)) j_cnt (
        .clk    (clk_i),
        .rstn   (rstn_i),
        .clear  (start_ok),
        .enable (i_wrap & two_dim),
        .len    (len1_q),
        .tc     (j_tc),
        .wrap   (j_wrap)
    );

    // Circular mode replays the same row, so only 2D strided moves the base.
    assign next_row_base = (mode_q == STRIDE2D) ?
                           row_base_q + L2_AWIDTH_NOAL'(len2_q) : row_base_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            addr_q     <= '0;
            row_base_q <= '0;
            dsize_q    <= '0;
            mode_q     <= LINEAR;
            len0_q     <= '0;
            len1_q     <= '0;
            len2_q     <= '0;
        end else if (start_ok) begin
            addr_q     <= cfg_start_addr_i;
            row_base_q <= cfg_start_addr_i;
            dsize_q    <= cfg_datasize_i;
            mode_q     <= filt_mode_e'(cfg_mode_i);
            len0_q     <= cfg_len0_i;
            len1_q     <= cfg_len1_i;
            len2_q     <= cfg_len2_i;
        end else if (hs && !last_elem) begin
            if (i_tc) begin
                row_base_q <= next_row_base;
                addr_q     <= next_row_base;
            end else begin
                addr_q <= addr_q + L2_AWIDTH_NOAL'(dsize_inc(filt_dsize_e'(dsize_q)));
            end
        end
    end

    assign addr_o     = addr_q;
    assign datasize_o = dsize_q;

`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || start_ok) begin
            stall_cnt <= '0;
        end else if (req_o && !gnt_i && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_udma_filter_tx_addrgen.sv
// Directed self-checking bench for udma_filter_tx_addrgen; inputs are driven
// and outputs sampled on the falling edge.
module tb_udma_filter_tx_addrgen;

    localparam int AW = 15;
    localparam int TS = 15;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cfg_start_i;
    logic [AW-1:0] cfg_start_addr_i;
    logic [1:0]    cfg_datasize_i;
    logic [1:0]    cfg_mode_i;
    logic [TS-1:0] cfg_len0_i, cfg_len1_i, cfg_len2_i;
    logic          req_o;
    logic          gnt_i;
    logic [AW-1:0] addr_o;
    logic [1:0]    datasize_o;
    logic          last_o, busy_o, done_o;
`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
    logic [15:0]   stall_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    udma_filter_tx_addrgen #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_start_addr_i (cfg_start_addr_i),
        .cfg_datasize_i   (cfg_datasize_i),
        .cfg_mode_i       (cfg_mode_i),
        .cfg_len0_i       (cfg_len0_i),
        .cfg_len1_i       (cfg_len1_i),
        .cfg_len2_i       (cfg_len2_i),
        .req_o            (req_o),
        .gnt_i            (gnt_i),
        .addr_o           (addr_o),
        .datasize_o       (datasize_o),
        .last_o           (last_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    // Called on a falling edge; returns on the falling edge of cycle t+1.
    task automatic apply_start(input logic [AW-1:0] a, input logic [1:0] ds, input logic [1:0] md,
                               input logic [TS-1:0] l0, input logic [TS-1:0] l1, input logic [TS-1:0] l2);
        cfg_start_addr_i = a;
        cfg_datasize_i   = ds;
        cfg_mode_i       = md;
        cfg_len0_i       = l0;
        cfg_len1_i       = l1;
        cfg_len2_i       = l2;
        cfg_start_i      = 1'b1;
        @(negedge clk_i);
        cfg_start_i      = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || last_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/last/busy/done=%b%b%b%b expected 0000", req_o, last_o, busy_o, done_o);
        end
        checks++;
        if (addr_o !== '0 || datasize_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_data: addr_o=%h datasize_o=%b expected 0000 00", addr_o, datasize_o);
        end
`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall: stall_cnt_o=%0d expected 0", stall_cnt_o);
        end
`endif
        rstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_linear_word();
        logic [AW-1:0] exp_addr [4];
        exp_addr = '{15'h100, 15'h104, 15'h108, 15'h10C};
        apply_start(15'h100, 2'b10, 2'b00, 15'd4, 15'd0, 15'd0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_o !== 1'b1 || busy_o !== 1'b1 || addr_o !== exp_addr[k] || datasize_o !== 2'b10) begin
                errors++;
                $display("FAIL linear_elem[%0d]: req=%b busy=%b addr=%h ds=%b expected req=1 busy=1 addr=%h ds=10",
                         k, req_o, busy_o, addr_o, datasize_o, exp_addr[k]);
            end
            checks++;
            if (last_o !== (k == 3)) begin
                errors++;
                $display("FAIL linear_last[%0d]: last_o=%b expected %b", k, last_o, (k == 3));
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1 || req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL linear_done: done=%b req=%b busy=%b expected 1 0 0", done_o, req_o, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || req_o !== 1'b0) begin
            errors++;
            $display("FAIL linear_idle: done=%b req=%b expected 0 0", done_o, req_o);
        end
    endtask

    task automatic test_2d_half();
        logic [AW-1:0] exp_addr [6];
        exp_addr = '{15'h200, 15'h202, 15'h204, 15'h220, 15'h222, 15'h224};
        apply_start(15'h200, 2'b01, 2'b01, 15'd3, 15'd2, 15'h20);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (req_o !== 1'b1 || addr_o !== exp_addr[k] || last_o !== (k == 5) || done_o !== 1'b0) begin
                errors++;
                $display("FAIL stride2d_elem[%0d]: req=%b addr=%h last=%b done=%b expected req=1 addr=%h last=%b done=0",
                         k, req_o, addr_o, last_o, done_o, exp_addr[k], (k == 5));
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL stride2d_done: done_o=%b expected 1", done_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL stride2d_done_once: done_o=%b expected 0", done_o);
        end
    endtask

    task automatic test_circular_byte();
        logic [AW-1:0] exp_addr [6];
        exp_addr = '{15'h40, 15'h41, 15'h40, 15'h41, 15'h40, 15'h41};
        apply_start(15'h40, 2'b00, 2'b10, 15'd2, 15'd3, 15'h77);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (req_o !== 1'b1 || addr_o !== exp_addr[k] || last_o !== (k == 5)) begin
                errors++;
                $display("FAIL circular_elem[%0d]: req=%b addr=%h last=%b expected req=1 addr=%h last=%b",
                         k, req_o, addr_o, last_o, exp_addr[k], (k == 5));
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL circular_done: done_o=%b expected 1", done_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        apply_start(15'h300, 2'b10, 2'b00, 15'd3, 15'd0, 15'd0);
        checks++;
        if (req_o !== 1'b1 || addr_o !== 15'h300) begin
            errors++;
            $display("FAIL bp_first: req=%b addr=%h expected 1 0300", req_o, addr_o);
        end
        @(negedge clk_i);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (req_o !== 1'b1 || addr_o !== 15'h304 || last_o !== 1'b0 || datasize_o !== 2'b10) begin
                errors++;
                $display("FAIL bp_hold[%0d]: req=%b addr=%h last=%b ds=%b expected 1 0304 0 10",
                         s, req_o, addr_o, last_o, datasize_o);
            end
            gnt_i = 1'b0;
            @(negedge clk_i);
        end
        gnt_i = 1'b1;
        checks++;
        if (req_o !== 1'b1 || addr_o !== 15'h304) begin
            errors++;
            $display("FAIL bp_release: req=%b addr=%h expected 1 0304", req_o, addr_o);
        end
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b1 || addr_o !== 15'h308 || last_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_last: req=%b addr=%h last=%b expected 1 0308 1", req_o, addr_o, last_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: done_o=%b expected 1", done_o);
        end
        @(negedge clk_i);
`ifdef UDMA_FILT_ADDRGEN_STALL_CNT_EN
        checks++;
        if (stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL bp_stall_cnt: stall_cnt_o=%0d expected 5", stall_cnt_o);
        end
`endif
    endtask

    task automatic test_empty();
        int req_seen, done_seen, first_done;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) apply_start(15'h80, 2'b10, 2'b00, 15'd0, 15'd5, 15'd0);
            else        apply_start(15'h80, 2'b10, 2'b01, 15'd3, 15'd0, 15'd4);
            req_seen   = 0;
            done_seen  = 0;
            first_done = -1;
            for (int k = 0; k < 4; k++) begin
                if (req_o === 1'b1) req_seen++;
                if (done_o === 1'b1) begin
                    done_seen++;
                    if (first_done < 0) first_done = k;
                end
                @(negedge clk_i);
            end
            checks++;
            if (req_seen != 0) begin
                errors++;
                $display("FAIL empty_noreq[%0d]: req cycles=%0d expected 0", c, req_seen);
            end
            checks++;
            if (done_seen != 1 || first_done > 1) begin
                errors++;
                $display("FAIL empty_done[%0d]: done pulses=%0d first at t+%0d expected 1 pulse by t+2",
                         c, done_seen, first_done + 1);
            end
        end
    endtask

    task automatic test_wrap();
        apply_start(15'h7FFE, 2'b10, 2'b00, 15'd2, 15'd0, 15'd0);
        checks++;
        if (addr_o !== 15'h7FFE || last_o !== 1'b0) begin
            errors++;
            $display("FAIL wrap_first: addr=%h last=%b expected 7ffe 0", addr_o, last_o);
        end
        @(negedge clk_i);
        checks++;
        if (addr_o !== 15'h0002 || last_o !== 1'b1) begin
            errors++;
            $display("FAIL wrap_second: addr=%h last=%b expected 0002 1", addr_o, last_o);
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_start_during_run();
        logic [AW-1:0] exp_addr [3];
        exp_addr = '{15'h500, 15'h504, 15'h508};
        apply_start(15'h500, 2'b10, 2'b00, 15'd3, 15'd0, 15'd0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_o !== 1'b1 || addr_o !== exp_addr[k] || datasize_o !== 2'b10 || last_o !== (k == 2)) begin
                errors++;
                $display("FAIL restart_elem[%0d]: req=%b addr=%h ds=%b last=%b expected 1 %h 10 %b",
                         k, req_o, addr_o, datasize_o, last_o, exp_addr[k], (k == 2));
            end
            cfg_start_i      = (k == 0);
            cfg_start_addr_i = 15'h600;
            cfg_datasize_i   = 2'b00;
            cfg_len0_i       = 15'd1;
            @(negedge clk_i);
        end
        cfg_start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: done_o=%b expected 1", done_o);
        end
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: req=%b busy=%b expected 0 0", req_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_start(15'h700, 2'b10, 2'b00, 15'd8, 15'd0, 15'd0);
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b1 || addr_o !== 15'h704) begin
            errors++;
            $display("FAIL rstmid_pre: req=%b addr=%h expected 1 0704", req_o, addr_o);
        end
        rstn_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || addr_o !== '0) begin
            errors++;
            $display("FAIL rstmid_abort: req=%b busy=%b done=%b addr=%h expected 0 0 0 0000",
                     req_o, busy_o, done_o, addr_o);
        end
        rstn_i = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (done_o === 1'b1 || req_o === 1'b1) seen++;
            @(negedge clk_i);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: req/done cycles=%0d expected 0", seen);
        end
    endtask

    task automatic test_fresh_start();
        logic [AW-1:0] exp_addr [3];
        exp_addr = '{15'h10, 15'h11, 15'h12};
        apply_start(15'h10, 2'b00, 2'b11, 15'd3, 15'd9, 15'd9);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_o !== 1'b1 || addr_o !== exp_addr[k] || last_o !== (k == 2) || datasize_o !== 2'b00) begin
                errors++;
                $display("FAIL fresh_elem[%0d]: req=%b addr=%h last=%b ds=%b expected 1 %h %b 00",
                         k, req_o, addr_o, last_o, datasize_o, exp_addr[k], (k == 2));
            end
            @(negedge clk_i);
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL fresh_done: done_o=%b expected 1", done_o);
        end
        @(negedge clk_i);
    endtask

    initial begin
        rstn_i           = 1'b0;
        cfg_start_i      = 1'b0;
        cfg_start_addr_i = '0;
        cfg_datasize_i   = 2'b00;
        cfg_mode_i       = 2'b00;
        cfg_len0_i       = '0;
        cfg_len1_i       = '0;
        cfg_len2_i       = '0;
        gnt_i            = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_linear_word();
        test_2d_half();
        test_circular_byte();
        test_backpressure();
        test_empty();
        test_wrap();
        test_start_during_run();
        test_reset_mid();
        test_fresh_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
